// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one main-memory request channel between the icache read port,
// the dcache read port and the dcache writeback port. Only one memory
// transaction is in flight at a time. Writebacks always win; the two
// read ports use fixed priority (dcache first) in the default build,
// or a 1-bit round-robin pointer when MEM_ARB_RR_EN is defined.
// All memory-side and response-side outputs are registered; the
// requester ready signals are combinational grants decoded in IDLE.
module mem_port_arbiter #(
   parameter int ADDR_BITS = 32,
   parameter int DW        = 256
) (
   input  logic                 clk,
   input  logic                 rst_n,

   // icache read request
   input  logic                 ic_req_valid_i,
   input  logic [ADDR_BITS-1:0] ic_req_addr_i,
   output logic                 ic_req_ready_o,

   // dcache read request
   input  logic                 dc_rd_valid_i,
   input  logic [ADDR_BITS-1:0] dc_rd_addr_i,
   output logic                 dc_rd_ready_o,

   // dcache writeback
   input  logic                 dc_wr_valid_i,
   input  logic [ADDR_BITS-1:0] dc_wr_addr_i,
   input  logic [DW-1:0]        dc_wr_data_i,
   output logic                 dc_wr_ready_o,

   // main-memory request channel
   output logic                 mem_valid_o,
   output logic                 mem_we_o,
   output logic [ADDR_BITS-1:0] mem_addr_o,
   output logic [DW-1:0]        mem_data_o,
   input  logic                 mem_ready_i,

   // main-memory read response
   input  logic                 mem_resp_valid_i,
   input  logic [DW-1:0]        mem_resp_data_i,

   // icache response
   output logic                 ic_resp_valid_o,
   output logic [DW-1:0]        ic_resp_data_o,

   // dcache response
   output logic                 dc_resp_valid_o,
   output logic [ADDR_BITS-1:0] dc_resp_addr_o,
   output logic [DW-1:0]        dc_resp_data_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t state;

   // Source of the in-flight read: 1 = dcache, 0 = icache.
   logic   src_dc;

   // Grant decode.
   logic   in_idle;
   logic   rd_allowed;
   logic   gnt_wr;
   logic   gnt_ic;
   logic   gnt_dc;
   logic   any_gnt;

`ifdef MEM_ARB_RR_EN
   // 0 favours icache, 1 favours dcache when both reads contend.
   logic   rr_ptr;
`endif

   // Decode at most one grant per cycle; the reset term keeps every
   // ready low while rst_n is held, independent of the clock.
   always_comb begin
      in_idle    = (state == IDLE) && rst_n;
      rd_allowed = in_idle && !dc_wr_valid_i;
      gnt_wr     = in_idle && dc_wr_valid_i;
`ifdef MEM_ARB_RR_EN
      gnt_ic     = rd_allowed && ic_req_valid_i && (!dc_rd_valid_i || !rr_ptr);
      gnt_dc     = rd_allowed && dc_rd_valid_i  && (!ic_req_valid_i || rr_ptr);
`else
      gnt_dc     = rd_allowed && dc_rd_valid_i;
      gnt_ic     = rd_allowed && ic_req_valid_i && !dc_rd_valid_i;
`endif
      any_gnt    = gnt_wr || gnt_ic || gnt_dc;
   end

   assign ic_req_ready_o = gnt_ic;
   assign dc_rd_ready_o  = gnt_dc;
   assign dc_wr_ready_o  = gnt_wr;

`ifdef MEM_ARB_RR_EN
   // After every read grant, point at the source that was not granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= 1'b0;
      end else if (gnt_ic || gnt_dc) begin
         rr_ptr <= gnt_ic;
      end
   end
`endif

   // Main FSM: latch the granted request, hold it on the memory channel
   // until accepted, then wait for the single outstanding read response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         src_dc          <= 1'b0;
         mem_valid_o     <= 1'b0;
         mem_we_o        <= 1'b0;
         mem_addr_o      <= '0;
         mem_data_o      <= '0;
         ic_resp_valid_o <= 1'b0;
         ic_resp_data_o  <= '0;
         dc_resp_valid_o <= 1'b0;
         dc_resp_addr_o  <= '0;
         dc_resp_data_o  <= '0;
      end else begin
         // Response strobes are single-cycle pulses by default.
         ic_resp_valid_o <= 1'b0;
         dc_resp_valid_o <= 1'b0;

         case (state)
            IDLE: begin
               if (any_gnt) begin
                  state       <= ISSUE;
                  mem_valid_o <= 1'b1;
                  mem_we_o    <= gnt_wr;
                  src_dc      <= gnt_dc;
                  if (gnt_wr) begin
                     mem_addr_o <= dc_wr_addr_i;
                     mem_data_o <= dc_wr_data_i;
                  end else if (gnt_dc) begin
                     mem_addr_o <= dc_rd_addr_i;
                     mem_data_o <= '0;
                  end else begin
                     mem_addr_o <= ic_req_addr_i;
                     mem_data_o <= '0;
                  end
               end
            end

            ISSUE: begin
               if (mem_ready_i) begin
                  mem_valid_o <= 1'b0;
                  // Writes complete on acceptance; reads need a response.
                  state       <= mem_we_o ? IDLE : WAIT;
               end
            end

            WAIT: begin
               if (mem_resp_valid_i) begin
                  state <= IDLE;
                  if (src_dc) begin
                     dc_resp_valid_o <= 1'b1;
                     dc_resp_data_o  <= mem_resp_data_i;
                     // mem_addr_o still holds the read address in WAIT.
                     dc_resp_addr_o  <= mem_addr_o;
                  end else begin
                     ic_resp_valid_o <= 1'b1;
                     ic_resp_data_o  <= mem_resp_data_i;
                  end
               end
            end

            default: begin
               state       <= IDLE;
               mem_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 32, which sets the request address width.
REQ-002 SHALL have parameter DW, default 256, which sets the cache block width.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst_n, input, 1, the reset; it is asynchronous and active-low.
REQ-005 SHALL have ports ic_req_valid_i (in, 1), ic_req_addr_i (in, ADDR_BITS) and ic_req_ready_o (out, 1), the icache read request.
REQ-006 SHALL have ports dc_rd_valid_i (in, 1), dc_rd_addr_i (in, ADDR_BITS) and dc_rd_ready_o (out, 1), the dcache read request.
REQ-007 SHALL have ports dc_wr_valid_i (in, 1), dc_wr_addr_i (in, ADDR_BITS), dc_wr_data_i (in, DW) and dc_wr_ready_o (out, 1), the dcache writeback.
REQ-008 SHALL have ports mem_valid_o (out, 1), mem_we_o (out, 1), mem_addr_o (out, ADDR_BITS), mem_data_o (out, DW) and mem_ready_i (in, 1), the single main-memory request channel.
REQ-009 SHALL have ports mem_resp_valid_i (in, 1) and mem_resp_data_i (in, DW), the main-memory read response.
REQ-010 SHALL have ports ic_resp_valid_o (out, 1) and ic_resp_data_o (out, DW), the icache response.
REQ-011 SHALL have ports dc_resp_valid_o (out, 1), dc_resp_addr_o (out, ADDR_BITS) and dc_resp_data_o (out, DW), the dcache response.

Function
REQ-012 SHALL implement an FSM with states IDLE, ISSUE and WAIT.
REQ-013 SHALL, in IDLE, grant at most one requester per cycle, with dc_wr taking priority over reads.
REQ-014 SHALL drive a requester's ready_o high only in IDLE, only when that requester is granted, and combinationally from its valid.
REQ-015 SHALL, on a grant in cycle N, latch addr, data, we and source, and assert mem_valid_o from N+1 in ISSUE.
REQ-016 SHALL hold mem_valid_o, mem_we_o, mem_addr_o and mem_data_o stable in ISSUE until mem_ready_i=1.
REQ-017 SHALL, on acceptance of a write, go ISSUE->IDLE; writes produce no response.
REQ-018 SHALL, on acceptance of a read, go ISSUE->WAIT; exactly one read is outstanding at any time.
REQ-019 SHALL, in WAIT on mem_resp_valid_i=1, register the response to the latched source's resp outputs, valid for exactly one cycle at the next edge, and go to IDLE.
REQ-020 SHALL drive dc_resp_addr_o with the latched dcache read address.
REQ-021 SHALL allow a new grant in the same cycle the response outputs are high, since the FSM is then in IDLE.
REQ-022 SHALL ignore mem_resp_valid_i outside WAIT.
REQ-023 SHALL, when no requester is valid in IDLE, remain in IDLE with all ready_o low.
REQ-024 SHALL drive mem_data_o as zero for reads.

Reset
REQ-025 SHALL, on rst_n=0 and regardless of clk, force state=IDLE, every valid and ready output to 0, every addr and data output to 0, and the round-robin pointer to favour icache.
REQ-026 SHALL, on reset mid-ISSUE or mid-WAIT, drop the in-flight request; a late response after reset is ignored per REQ-022.

Configuration
REQ-027 SHALL, when macro MEM_ARB_RR_EN is defined, arbitrate the two reads round-robin: a 1-bit pointer toggles to the other source after each read grant, and a lone valid requester is always granted.
REQ-028 SHALL, when MEM_ARB_RR_EN is undefined, arbitrate the reads with fixed priority, dc_rd over ic_req, and implement no pointer.
REQ-029 SHALL, in both configurations, keep write priority per REQ-013.

Verification
REQ-030 SHALL verify: dc_wr addr=0x100, data=0xAA.., mem_ready_i=1 -> dc_wr_ready_o at N, mem_valid_o=1 with we=1 at N+1, back in IDLE at N+2, and no response.
REQ-031 SHALL verify: ic_req addr=0x40, mem_ready_i low 3 cycles then high, response 0x55.. two cycles later -> mem outputs held for 4 cycles, then ic_resp_valid_o=1 for one cycle with data 0x55...
REQ-032 SHALL verify: ic_req, dc_rd and dc_wr all valid in IDLE -> write granted first; with MEM_ARB_RR_EN, reads then granted ic then dc; without MEM_ARB_RR_EN, dc then ic.
REQ-033 SHALL verify: dc_rd addr=0x2C0 -> dc_resp_valid_o=1 with dc_resp_addr_o=0x2C0, and a stray mem_resp_valid_i pulse in IDLE produces no output.
REQ-034 SHALL verify: rst_n asserted in WAIT, then a response arrives -> all outputs are 0, no resp valid is produced, and the next request is served normally.
REQ-035 SHALL verify: a continuously valid ic_req alone for 5 transactions -> each is granted, with no starvation in either configuration.
